// File: rtl/rif_pkg.sv
// Shared types for the register-interface arbiter. The payload struct is sized by
// the RIF_* widths below; the arbiter's width parameters default to the same values.
package rif_pkg;

    localparam int RIF_ADDR_W = 12;
    localparam int RIF_DATA_W = 32;
    localparam int RIF_STRB_W = RIF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } rif_arb_state_e;

    typedef struct packed {
        logic [RIF_ADDR_W-1:0] addr;
        logic                  wr;
        logic [RIF_STRB_W-1:0] wstrb;
        logic [RIF_DATA_W-1:0] wdata;
    } rif_req_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest pending index at or above ptr, wrapping,
// found by searching a doubled request vector with the bits below ptr masked off.
module rr_arbiter
    import rif_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;

    always_comb begin
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        dbl       = {pend, pend};
        masked    = '0;
        for (int k = 0; k < 2*NUM_REQ; k++) begin
            masked[k] = dbl[k] & (k >= int'(ptr));
        end
        // Walk downward so the lowest set bit is the last one written.
        for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
            if (masked[k]) begin
                idx       = IDX_W'(k % NUM_REQ);
                any_valid = 1'b1;
            end
        end
        if (any_valid) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/rif_arbiter.sv
// Shares one RIF target between NUM_REQ requesters: round-robin pick, one-cycle
// RIF strobe, then a registered response to the winner on the following cycle.
module rif_arbiter
    import rif_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_WIDTH = RIF_ADDR_W,
    parameter  int DATA_WIDTH = RIF_DATA_W,
    parameter  int BYTE_COUNT = DATA_WIDTH / 8,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ-1:0]               req_rd,
    input  logic [NUM_REQ*BYTE_COUNT-1:0]    req_wstrb,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_err,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            rif_addr,
    output logic                             rif_wr_req,
    output logic                             rif_rd_req,
    output logic [BYTE_COUNT-1:0]            rif_wstrb,
    output logic [DATA_WIDTH-1:0]            rif_wdata,
    input  logic                             rif_addr_valid,
    input  logic [DATA_WIDTH-1:0]            rif_rdata,
    output logic [1:0]                       dbg_state
);

    // Handshake: a requester raises req_wr/req_rd with its payload and holds it until
    // the cycle req_gnt[i] is high; that cycle is the RIF access, and rsp_valid[i]
    // pulses exactly one cycle later. The requester must drop the request after gnt.

    rif_arb_state_e   state;
    rif_req_t         req_q;
    rif_req_t         win_req;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx_q;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] win_gnt;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    assign pend = req_wr | req_rd;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .pend      (pend),
        .ptr       (ptr),
        .gnt       (win_gnt),
        .idx       (win_idx),
        .any_valid (win_any)
    );

    always_comb begin
        win_req.addr  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        win_req.wr    = req_wr[win_idx];
        win_req.wstrb = req_wstrb[win_idx*BYTE_COUNT +: BYTE_COUNT];
        win_req.wdata = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // RIF side is decoded from state and the payload register only, never from req_*.
    assign rif_addr   = req_q.addr;
    assign rif_wdata  = req_q.wdata;
    assign rif_wr_req = (state == ISSUE) &  req_q.wr;
    assign rif_rd_req = (state == ISSUE) & ~req_q.wr;
    assign rif_wstrb  = rif_wr_req ? req_q.wstrb : '0;
    assign dbg_state  = state;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            ptr       <= '0;
            idx_q     <= '0;
            req_q     <= '0;
            req_gnt   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            req_gnt   <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE, RESP: begin
                    if (win_any) begin
                        state   <= ISSUE;
                        req_q   <= win_req;
                        idx_q   <= win_idx;
                        req_gnt <= win_gnt;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state     <= RESP;
                    rsp_valid <= req_gnt;
                    rsp_err   <= ~rif_addr_valid;
                    rsp_rdata <= (!req_q.wr && rif_addr_valid) ? rif_rdata : '0;
                    ptr       <= (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rif_arbiter.sv
// Bench for rif_arbiter: a cycle-schedule model of the arbiter plus a small target
// model, compared every cycle, with literal checks on the directed scenarios.
module tb_rif_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int BC   = 4;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ-1:0]    req_wr    = '0;
    logic [NREQ-1:0]    req_rd    = '0;
    logic [NREQ*BC-1:0] req_wstrb = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_gnt, rsp_valid;
    logic               rsp_err;
    logic [DW-1:0]      rsp_rdata;
    logic [AW-1:0]      rif_addr;
    logic               rif_wr_req, rif_rd_req;
    logic [BC-1:0]      rif_wstrb;
    logic [DW-1:0]      rif_wdata;
    logic               rif_addr_valid;
    logic [DW-1:0]      rif_rdata;
    logic [1:0]         dbg_state;

    rif_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BC)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_addr(req_addr), .req_wr(req_wr), .req_rd(req_rd),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .rif_addr(rif_addr), .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req),
        .rif_wstrb(rif_wstrb), .rif_wdata(rif_wdata),
        .rif_addr_valid(rif_addr_valid), .rif_rdata(rif_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    // ---------------- target model ----------------
    function automatic logic tgt_valid(input logic [AW-1:0] a);
        return a != 12'hFFC;
    endfunction
    function automatic logic [DW-1:0] tgt_rdata(input logic [AW-1:0] a);
        return (a == 12'h010) ? 32'hCAFEF00D : (32'h5A000000 | {20'h0, a});
    endfunction
    assign rif_addr_valid = tgt_valid(rif_addr);
    assign rif_rdata      = tgt_rdata(rif_addr);

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_err    = 0;
    int m_cyc    = 0;
    int m_ptr    = 0;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            wr;
        logic            rd;
        logic [AW-1:0]   addr;
        logic [BC-1:0]   wstrb;
        logic [DW-1:0]   wdata;
        logic [NREQ-1:0] rv;
        logic            err;
        logic [DW-1:0]   rdata;
    } exp_t;
    exp_t sched[int];

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [BC-1:0] wstrb;
        logic [DW-1:0] wdata;
    } cmd_t;
    cmd_t cq0[$];
    cmd_t cq1[$];

    typedef struct {
        int            idx;
        int            cyc;
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [BC-1:0] wstrb;
        logic [DW-1:0] wdata;
    } glog_t;
    typedef struct {
        int            idx;
        int            cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } rlog_t;
    glog_t glog[$];
    rlog_t rlog[$];

    logic [1:0] exp_q[$];
    bit active[NREQ];
    bit cool[NREQ];
    int ld_cyc[NREQ];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, m_cyc, act, expv);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic cmd_t mk(input logic wr, input logic rd, input logic [AW-1:0] a,
                                input logic [BC-1:0] s, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.rd = rd; c.addr = a; c.wstrb = s; c.wdata = d;
        return c;
    endfunction

    task automatic push(input int i, input cmd_t c);
        if (i == 0) cq0.push_back(c);
        else        cq1.push_back(c);
    endtask

    task automatic set_req(input int i, input cmd_t c);
        req_wr[i]             = c.wr;
        req_rd[i]             = c.rd;
        req_addr[i*AW +: AW]  = c.addr;
        req_wstrb[i*BC +: BC] = c.wstrb;
        req_wdata[i*DW +: DW] = c.wdata;
    endtask

    // ---------------- behavioural model ----------------
    // A pick made in cycle c occupies the RIF in c+1 and responds in c+2; a pick is
    // possible in any cycle that is not itself an RIF access cycle.
    always @(posedge HCLK) begin
        exp_t e;
        exp_t r;
        int   w;
        bit   found;
        if (HRESET) begin
            sched.delete();
            m_ptr = 0;
        end else if (!(sched.exists(m_cyc) && sched[m_cyc].gnt != '0)) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!found && (req_wr[j] || req_rd[j])) begin
                    found = 1'b1;
                    w     = j;
                end
            end
            if (found) begin
                e       = '0;
                e.gnt   = NREQ'(1 << w);
                e.wr    = req_wr[w];
                e.rd    = !req_wr[w];
                e.addr  = req_addr[w*AW +: AW];
                e.wstrb = req_wr[w] ? req_wstrb[w*BC +: BC] : '0;
                e.wdata = req_wdata[w*DW +: DW];
                sched[m_cyc+1] = e;
                r       = '0;
                r.rv    = e.gnt;
                r.err   = !tgt_valid(e.addr);
                r.rdata = (e.rd && tgt_valid(e.addr)) ? tgt_rdata(e.addr) : '0;
                sched[m_cyc+2] = r;
                m_ptr = (w + 1) % NREQ;
            end
        end
        m_cyc++;
    end

    // ---------------- compare + requester driver ----------------
    always @(negedge HCLK) begin
        exp_t  e;
        cmd_t  c;
        glog_t g;
        rlog_t rr;
        e = '0;
        if (!HRESET && sched.exists(m_cyc)) e = sched[m_cyc];
        chk("req_gnt",    req_gnt,    e.gnt);
        chk("rif_wr_req", rif_wr_req, e.wr);
        chk("rif_rd_req", rif_rd_req, e.rd);
        chk("rif_wstrb",  rif_wstrb,  e.wstrb);
        chk("rsp_valid",  rsp_valid,  e.rv);
        chk("rsp_err",    rsp_err,    e.err);
        chk("rsp_rdata",  rsp_rdata,  e.rdata);
        if (e.gnt != '0) begin
            chk("rif_addr",  rif_addr,  e.addr);
            chk("rif_wdata", rif_wdata, e.wdata);
        end
        if (req_gnt != '0) begin
            g.idx = oh_idx(req_gnt); g.cyc = m_cyc; g.wr = rif_wr_req; g.rd = rif_rd_req;
            g.addr = rif_addr; g.wstrb = rif_wstrb; g.wdata = rif_wdata;
            glog.push_back(g);
        end
        if (rsp_valid != '0) begin
            rr.idx = oh_idx(rsp_valid); rr.cyc = m_cyc; rr.err = rsp_err; rr.rdata = rsp_rdata;
            rlog.push_back(rr);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (active[i] && req_gnt[i] && !HRESET) begin
                active[i] = 1'b0;
                cool[i]   = 1'b1;
                set_req(i, '0);
            end else if (cool[i]) begin
                cool[i] = 1'b0;
            end else if (!active[i] && ((i == 0) ? cq0.size() : cq1.size()) > 0) begin
                c = (i == 0) ? cq0.pop_front() : cq1.pop_front();
                set_req(i, c);
                active[i] = 1'b1;
                ld_cyc[i] = m_cyc;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cq0.size() != 0 || cq1.size() != 0 || active[0] || active[1] || cool[0] || cool[1])
               && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        chk("idle_reached", (n < 200), 1);
        repeat (4) @(negedge HCLK);
    endtask

    task automatic reset_in_issue(input int who);
        int n;
        n = 0;
        while (!req_gnt[who] && n < 40) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        chk("rst_saw_gnt", req_gnt[who], 1);
        #1 HRESET = 1'b1;
        #1;
        chk("rst_async_gnt",   req_gnt,    0);
        chk("rst_async_rd",    rif_rd_req, 0);
        chk("rst_async_wr",    rif_wr_req, 0);
        chk("rst_async_state", dbg_state,  0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int g0, r0, rs;
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("reset_rif_addr",  rif_addr,  0);
        chk("reset_rif_wdata", rif_wdata, 0);
        chk("reset_state",     dbg_state, 0);
        HRESET = 1'b0;
        repeat (2) @(negedge HCLK);

        // single read
        g0 = glog.size(); r0 = rlog.size();
        push(0, mk(1'b0, 1'b1, 12'h010, 4'h0, 32'h0));
        wait_idle();
        chk("rd_gnt_count", glog.size() - g0, 1);
        chk("rd_gnt_idx",   glog[g0].idx, 0);
        chk("rd_rif_rd",    glog[g0].rd, 1);
        chk("rd_rif_addr",  glog[g0].addr, 12'h010);
        chk("rd_lat_gnt",   glog[g0].cyc - ld_cyc[0], 1);
        chk("rd_rsp_idx",   rlog[r0].idx, 0);
        chk("rd_rsp_rdata", rlog[r0].rdata, 32'hCAFEF00D);
        chk("rd_rsp_err",   rlog[r0].err, 0);
        chk("rd_lat_rsp",   rlog[r0].cyc - glog[g0].cyc, 1);

        // write with strobes
        g0 = glog.size(); r0 = rlog.size();
        push(1, mk(1'b1, 1'b0, 12'h024, 4'b0011, 32'h12345678));
        wait_idle();
        chk("wr_gnt_idx",   glog[g0].idx, 1);
        chk("wr_rif_wr",    glog[g0].wr, 1);
        chk("wr_rif_rd",    glog[g0].rd, 0);
        chk("wr_rif_addr",  glog[g0].addr, 12'h024);
        chk("wr_rif_wstrb", glog[g0].wstrb, 4'b0011);
        chk("wr_rif_wdata", glog[g0].wdata, 32'h12345678);
        chk("wr_rsp_rdata", rlog[r0].rdata, 0);
        chk("wr_rsp_err",   rlog[r0].err, 0);

        // fairness under continuous load
        g0 = glog.size();
        for (int k = 0; k < 3; k++) begin
            push(0, mk(1'b0, 1'b1, AW'(12'h100 + 4*k), 4'h0, 32'h0));
            push(1, mk(1'b0, 1'b1, AW'(12'h200 + 4*k), 4'h0, 32'h0));
        end
        for (int k = 0; k < 6; k++) exp_q.push_back(2'(k % 2));
        wait_idle();
        chk("fair_gnt_count", glog.size() - g0, 6);
        for (int k = 0; k < 6; k++) begin
            chk("fair_order", glog[g0+k].idx, exp_q.pop_front());
            if (k > 0) chk("fair_spacing", glog[g0+k].cyc - glog[g0+k-1].cyc, 2);
        end

        // decode error then a clean access
        r0 = rlog.size();
        push(0, mk(1'b0, 1'b1, 12'hFFC, 4'h0, 32'h0));
        push(0, mk(1'b0, 1'b1, 12'h000, 4'h0, 32'h0));
        wait_idle();
        chk("derr_rsp_count", rlog.size() - r0, 2);
        chk("derr_err",       rlog[r0].err, 1);
        chk("derr_rdata",     rlog[r0].rdata, 0);
        chk("derr_next_err",  rlog[r0+1].err, 0);
        chk("derr_next_data", rlog[r0+1].rdata, 32'h5A000000);

        // write and read both asserted
        g0 = glog.size(); r0 = rlog.size();
        push(1, mk(1'b1, 1'b1, 12'h030, 4'hF, 32'hDEADBEEF));
        wait_idle();
        chk("wrrd_wr",    glog[g0].wr, 1);
        chk("wrrd_rd",    glog[g0].rd, 0);
        chk("wrrd_wstrb", glog[g0].wstrb, 4'hF);
        chk("wrrd_rdata", rlog[r0].rdata, 0);

        // reset during ISSUE of requester 0 while the pointer sits at 1
        push(0, mk(1'b0, 1'b1, 12'h040, 4'h0, 32'h0));
        wait_idle();
        push(0, mk(1'b0, 1'b1, 12'h044, 4'h0, 32'h0));
        rs = rlog.size();
        reset_in_issue(0);
        push(1, mk(1'b0, 1'b1, 12'h048, 4'h0, 32'h0));
        repeat (3) @(negedge HCLK);
        chk("rstA_no_rsp", rlog.size() - rs, 0);
        g0 = glog.size(); r0 = rlog.size();
        HRESET = 1'b0;
        wait_idle();
        chk("rstA_gnt_count", glog.size() - g0, 2);
        chk("rstA_tie_first", glog[g0].idx, 0);
        chk("rstA_tie_addr",  glog[g0].addr, 12'h044);
        chk("rstA_second",    glog[g0+1].idx, 1);
        chk("rstA_rsp_data",  rlog[r0].rdata, 32'h5A000044);

        // reset during ISSUE of requester 1 with only it pending
        push(1, mk(1'b0, 1'b1, 12'h050, 4'h0, 32'h0));
        rs = rlog.size();
        reset_in_issue(1);
        repeat (3) @(negedge HCLK);
        chk("rstB_no_rsp", rlog.size() - rs, 0);
        g0 = glog.size(); r0 = rlog.size();
        HRESET = 1'b0;
        wait_idle();
        chk("rstB_gnt_count", glog.size() - g0, 1);
        chk("rstB_gnt_idx",   glog[g0].idx, 1);
        chk("rstB_rsp_idx",   rlog[r0].idx, 1);
        chk("rstB_rsp_data",  rlog[r0].rdata, 32'h5A000050);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", m_cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
